// File: rtl/register_file.sv
// Multi-port register file: one write port, two combinational read ports,
// optional hardwired zero register, optional write-to-read forwarding and a saturating write counter.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             armed;
    logic             zero_hit;
    logic             commit;

    // armed stays low through the first edge after reset release, so a write
    // presented on the releasing edge is dropped whatever the rst/clk ordering.
    assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
    assign commit   = we && armed && !zero_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            wr_count <= 16'h0000;
            regs     <= '{default: '0};
        end else begin
            armed <= 1'b1;
            if (commit) begin
                regs[waddr] <= wdata;
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(
        input logic              rst_now,
        input logic              fwd,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd,
        input logic [ADDR_W-1:0] ra,
        input logic [WIDTH-1:0]  stored
    );
        if (rst_now) begin
            return '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && fwd && (wa == ra)) begin
            return wd;
        end
        return stored;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, commit, waddr, wdata, raddr1, regs[raddr1]);
        rdata2 = read_port(rst, commit, waddr, wdata, raddr2, regs[raddr2]);
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, hand sequences for reset/bypass/saturation,
// randomized traffic against an array model, and a small-geometry parameter sweep.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic [15:0] wr_count, nb_wr_count;

    logic        s_we;
    logic [2:0]  s_waddr, s_raddr1, s_raddr2;
    logic [7:0]  s_wdata;
    logic [7:0]  sz_rdata1, sz_rdata2, so_rdata1, so_rdata2;
    logic [15:0] sz_wr_count, so_wr_count;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .wr_count(wr_count)
    );

    register_file #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(nb_rdata1), .raddr2(raddr2), .rdata2(nb_rdata2),
        .wr_count(nb_wr_count)
    );

    register_file #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_sz (
        .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .rdata1(sz_rdata1), .raddr2(s_raddr2), .rdata2(sz_rdata2),
        .wr_count(sz_wr_count)
    );

    register_file #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_so (
        .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .rdata1(so_rdata1), .raddr2(s_raddr2), .rdata2(so_rdata2),
        .wr_count(so_wr_count)
    );

    // Reference model: one memory image per configuration and a saturating counter.
    logic [31:0] m_z [32];
    logic [31:0] m_n [32];
    int          cz, cn;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_zero_byp(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we && waddr == a) return wdata;
        return m_z[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_z[i] = 32'h0;
            m_n[i] = 32'h0;
        end
        cz = 0;
        cn = 0;
    endtask

    task automatic model_commit();
        if (we) begin
            if (waddr != 5'd0) begin
                m_z[waddr] = wdata;
                if (cz < 65535) cz++;
            end
            m_n[waddr] = wdata;
            if (cn < 65535) cn++;
        end
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic cycle(input bit chk);
        #1;
        if (chk) begin
            check("rand_rd1", rdata1, ref_zero_byp(raddr1));
            check("rand_rd2", rdata2, ref_zero_byp(raddr2));
            check("rand_nb_rd1", nb_rdata1, m_n[raddr1]);
            check("rand_nb_rd2", nb_rdata2, m_n[raddr2]);
        end
        @(posedge clk);
        model_commit();
        #1;
        if (chk) begin
            check("rand_cnt", {16'h0, wr_count}, cz);
            check("rand_nb_cnt", {16'h0, nb_wr_count}, cn);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        we = 1'b0; s_we = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        we = 1'b0;
        cycle(0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;
        model_reset();

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        16'd1};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        tbl[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0,        32'h0,        16'd1};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 16'd1};
        tbl[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd2};
        tbl[5] = '{1'b1, 5'd5, 32'h00000011, 5'd5, 5'd7, 32'h00000011, 32'hA5A5A5A5, 16'd3};
        tbl[6] = '{1'b0, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd31, 32'h00000011, 32'h0,       16'd3};

        @(negedge clk);
        #1;
        check("rst_rd1", rdata1, 32'h0);
        check("rst_cnt", {16'h0, wr_count}, 32'h0);
        check("rst_nb_cnt", {16'h0, nb_wr_count}, 32'h0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            raddr1 = tbl[i].r1; raddr2 = tbl[i].r2;
            #1;
            check($sformatf("tbl%0d_rd1", i), rdata1, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), rdata2, tbl[i].e2);
            @(posedge clk);
            model_commit();
            #1;
            check($sformatf("tbl%0d_cnt", i), {16'h0, wr_count}, {16'h0, tbl[i].ec});
            @(negedge clk);
        end

        // Forwarding versus no forwarding on the same write.
        do_reset();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("byp_rd1", rdata1, 32'hA5A5A5A5);
        check("byp_rd2", rdata2, 32'hA5A5A5A5);
        check("nobyp_old_rd1", nb_rdata1, 32'h0);
        check("nobyp_old_rd2", nb_rdata2, 32'h0);
        @(posedge clk); model_commit(); @(negedge clk);
        we = 1'b0;
        #1;
        check("nobyp_new_rd1", nb_rdata1, 32'hA5A5A5A5);
        check("nobyp_new_rd2", nb_rdata2, 32'hA5A5A5A5);
        @(negedge clk);

        // Address 0: discarded on the zero-reg instance, ordinary on the other.
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_wr_rd1", rdata1, 32'h0);
        check("x0_nb_wr_rd1", nb_rdata1, 32'h0);
        @(posedge clk); model_commit(); #1;
        check("x0_cnt", {16'h0, wr_count}, 32'd1);
        check("x0_nb_cnt", {16'h0, nb_wr_count}, 32'd2);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_after_rd1", rdata1, 32'h0);
        check("x0_nb_after_rd1", nb_rdata1, 32'h12345678);
        @(negedge clk);

        // Async reset between edges, writes held off while asserted.
        we = 1'b1; waddr = 5'd3; wdata = 32'h1; raddr1 = 5'd3; raddr2 = 5'd3;
        cycle(1);
        we = 1'b0;
        #1;
        check("x3_rd1", rdata1, 32'h1);
        #2;
        rst = 1'b1;
        we = 1'b1; wdata = 32'hFF;
        model_reset();
        #1;
        check("arst_rd1", rdata1, 32'h0);
        check("arst_rd2", rdata2, 32'h0);
        check("arst_nb_rd1", nb_rdata1, 32'h0);
        check("arst_cnt", {16'h0, wr_count}, 32'h0);
        check("arst_nb_cnt", {16'h0, nb_wr_count}, 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge_rd1", rdata1, 32'h0);
        check("arst_edge_cnt", {16'h0, wr_count}, 32'h0);
        @(posedge clk);
        rst = 1'b0;
        #1;
        we = 1'b0;
        #1;
        check("rel_edge_rd1", rdata1, 32'h0);
        check("rel_edge_nb_rd1", nb_rdata1, 32'h0);
        check("rel_edge_cnt", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        cycle(0);
        we = 1'b1; waddr = 5'd3; wdata = 32'h2;
        cycle(1);
        we = 1'b0;
        cycle(1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            cycle(1);
            if (rdata1 !== rdata2 && raddr1 == raddr2) check("same_addr", rdata2, rdata1);
        end

        // Saturating write counter.
        do_reset();
        we = 1'b1; waddr = 5'd1; raddr1 = 5'd1; raddr2 = 5'd2;
        for (int n = 0; n < 65534; n++) begin
            wdata = n;
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end
        check("sat_fffe", {16'h0, wr_count}, 32'h0000FFFE);
        cycle(0);
        cycle(0);
        check("sat_ffff", {16'h0, wr_count}, 32'h0000FFFF);
        check("sat_nb_ffff", {16'h0, nb_wr_count}, 32'h0000FFFF);
        cycle(1);
        check("sat_hold", {16'h0, wr_count}, 32'h0000FFFF);
        we = 1'b0;

        // Small geometry: every register written with index+1.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_we = 1'b1; s_waddr = 3'(i); s_wdata = 8'(i + 1);
            @(posedge clk);
            @(negedge clk);
        end
        s_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_raddr1 = 3'(i); s_raddr2 = 3'(7 - i);
            #1;
            check($sformatf("sw_z_r%0d", i), {24'h0, sz_rdata1}, (i == 0) ? 32'd0 : i + 1);
            check($sformatf("sw_z2_r%0d", 7 - i), {24'h0, sz_rdata2}, (i == 7) ? 32'd0 : 8 - i);
            check($sformatf("sw_o_r%0d", i), {24'h0, so_rdata1}, i + 1);
            @(negedge clk);
        end
        check("sw_z_cnt", {16'h0, sz_wr_count}, 32'd7);
        check("sw_o_cnt", {16'h0, so_wr_count}, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the address width; register count DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1 and is an ordinary register when 0.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write data is forwarded to the read ports when 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port we, input, 1 bit: write enable.
REQ-008 Port waddr, input, ADDR_W bits: write address.
REQ-009 Port wdata, input, WIDTH bits: write data.
REQ-010 Port raddr1, input, ADDR_W bits: read port 1 address.
REQ-011 Port rdata1, output, WIDTH bits: read port 1 data.
REQ-012 Port raddr2, input, ADDR_W bits: read port 2 address.
REQ-013 Port rdata2, output, WIDTH bits: read port 2 data.
REQ-014 Port wr_count, output, 16 bits: count of committed writes since reset.

Function
REQ-015 Storage SHALL be DEPTH registers of WIDTH bits each.
REQ-016 A write SHALL commit wdata to register waddr on the rising clk edge when we=1 and rst=0.
REQ-017 With ZERO_REG=1, a write to address 0 SHALL be discarded, and register 0 SHALL always read 0.
REQ-018 With ZERO_REG=0, address 0 SHALL behave like every other register.
REQ-019 When we=0, no register SHALL change.
REQ-020 Reads SHALL be combinational (zero latency): rdataN = contents of register raddrN in the same cycle.
REQ-021 With BYPASS=1, when we=1, waddr=raddrN and the write is not discarded, rdataN SHALL equal wdata in that same cycle.
REQ-022 With BYPASS=1, a discarded write to address 0 SHALL NOT be forwarded; rdataN SHALL read 0.
REQ-023 With BYPASS=0, rdataN SHALL show the old contents during the write cycle and the new value from the next cycle on.
REQ-024 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-025 wr_count SHALL increment by 1 on each committed (non-discarded) write.
REQ-026 wr_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 Discarded writes to register 0 SHALL NOT increment wr_count.

Reset
REQ-028 Asserting rst SHALL immediately clear all registers and wr_count to 0, without waiting for a clk edge.
REQ-029 While rst=1, writes SHALL be ignored, and rdata1 and rdata2 SHALL read 0 regardless of BYPASS.
REQ-030 A write presented on the same edge at which rst deasserts SHALL be ignored; writes SHALL take effect from the following edge.
REQ-031 Reset asserted mid-operation (between edges) SHALL override any pending write.

Verification
REQ-032 Write/readback: reset, then write x5=32'hDEADBEEF, set raddr1=5 on the next cycle -> rdata1=32'hDEADBEEF, wr_count=1.
REQ-033 Zero register: with ZERO_REG=1, write x0=32'h12345678 with raddr1=0 -> rdata1=0 in the write cycle and afterwards, wr_count unchanged.
REQ-034 Bypass: with BYPASS=1, in one cycle apply we=1, waddr=7, wdata=32'hA5A5A5A5, raddr1=raddr2=7 -> both ports read 32'hA5A5A5A5 in that cycle. With BYPASS=0 -> both read the old value 0, then 32'hA5A5A5A5 on the next cycle.
REQ-035 Async reset: write x3=32'h1, then pulse rst mid-cycle with no clk edge -> rdata for x3 reads 0 immediately and wr_count=0.
REQ-036 Saturation: perform 65536 writes to x1 -> wr_count=16'hFFFF; one more write -> wr_count stays 16'hFFFF.
REQ-037 Parameter sweep: instantiate WIDTH=8, ADDR_W=3 and write all 8 registers with their index+1 -> readback returns 1..8, except index 0 returns 0 when ZERO_REG=1.
